io_hub: RTL and testbench
=========================

Name: io_hub

Overview:
- Parametrised memory-mapped I/O hub between the CPU datapath's I/O port and NUM_CH peripheral channels, for example the hex driver, the VGA driver and future devices.
- The hub decodes the upper address bits into a channel index.
- Each channel has its own write FIFO, so a slow peripheral does not stall unrelated traffic.
- Reads are registered and returned one cycle later. Unmapped accesses are counted.

Parameters:
- DATA_W, 16, data width of the CPU side and all channels.
- ADDR_W, 16, CPU address width.
- SEL_W, 2, number of upper address bits used as the channel index.
- NUM_CH, 3, number of implemented channels; 1 <= NUM_CH <= 2**SEL_W.
- DEPTH, 4, entries per channel write FIFO; a power of two, at least 2.
- LOCAL_W = ADDR_W-SEL_W (derived), width of the channel-local address.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_waddr  in  ADDR_W  write address.
- cpu_wdata  in  DATA_W  write data.
- cpu_wenable  in  1  write request.
- cpu_stall  out  1  write refused this cycle; the CPU must hold waddr, wdata and wenable.
- cpu_raddr  in  ADDR_W  read address, sampled every cycle.
- cpu_rdata  out  DATA_W  registered read data.
- ch_wvalid  out  NUM_CH  per channel: FIFO head is valid.
- ch_waddr  out  NUM_CH*LOCAL_W  per-channel head address, packed with channel i at slice i.
- ch_wdata  out  NUM_CH*DATA_W  per-channel head data.
- ch_wready  in  NUM_CH  per channel: peripheral accepts the head this cycle.
- ch_raddr  out  NUM_CH*LOCAL_W  local read address, broadcast to every slice.
- ch_rdata  in  NUM_CH*DATA_W  combinational read data from each peripheral.
- ch_busy  out  NUM_CH  per channel: FIFO not empty.
- err_count  out  8  saturating count of unmapped accesses.

Behaviour:
- Decode:
  - sel = addr[ADDR_W-1 -: SEL_W]; local = addr[LOCAL_W-1:0].
  - The access is unmapped when sel >= NUM_CH.
- Reset (reset=0, asynchronous):
  - All FIFOs empty, with pointers and counts set to 0.
  - ch_wvalid=0, ch_busy=0, cpu_rdata=0, err_count=0.
  - Reset mid-transfer discards all queued writes; no ch_wvalid glitch is allowed after reset asserts.
- Push:
  - A write is accepted when cpu_wenable=1, sel is mapped and count[sel] < DEPTH. The entry {local, wdata} is written at the tail.
  - cpu_stall = cpu_wenable & mapped & (count[sel]==DEPTH). This is combinational from registered count.
  - Full is judged on registered count: a push to a full FIFO is refused even if that FIFO pops in the same cycle.
- Pop:
  - Per channel, on ch_wvalid[i] & ch_wready[i]: the head advances.
  - ch_wvalid[i] = (count[i]!=0). Head fields are stable while ch_wvalid=1 and ch_wready=0.
- Counts:
  - Push and pop on the same channel in the same cycle leave the count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Channels are fully independent; a full channel never blocks a write to another channel.
- Write ordering:
  - FIFO order is preserved within a channel.
  - There is no ordering between channels.
- Reads:
  - ch_raddr = cpu_raddr[LOCAL_W-1:0] every cycle.
  - On each clock edge, cpu_rdata <= ch_rdata slice selected by sel(cpu_raddr), or 0 if unmapped. Latency is 1 cycle.
  - Reads do not wait for queued writes. Software polls ch_busy, via a peripheral status register, for read-after-write ordering.
- Unmapped accesses:
  - An unmapped write with cpu_wenable=1 is dropped, cpu_stall=0, and err_count increments.
  - err_count increments by at most 1 per cycle, even when an unmapped read and an unmapped write occur together.
  - err_count saturates at 255.
  - An unmapped read returns 0 and increments err_count. It counts only on a change of cpu_raddr into the unmapped region, i.e. the first cycle in which it is unmapped.
- ch_busy = ch_wvalid.

Test Plan:
- Reset then idle, with defaults:
  - Required: all outputs 0.
  - Required: ch_raddr follows cpu_raddr[13:0].
- Single write: waddr=16'h4005, wdata=16'hBEEF.
  - Required: next cycle, ch_wvalid=3'b010, ch_waddr slice1=14'h0005, ch_wdata slice1=16'hBEEF.
  - Required: after ch_wready[1]=1 for one cycle, ch_wvalid[1]=0.
- Fill channel 0, with ch_wready=0:
  - Required: 4 writes are accepted, and the 5th shows cpu_stall=1.
  - With ch_wready[0]=1: the stall clears on the cycle after the first pop.
  - Required: data drains in order 1, 2, 3, 4, 5.
- Cross-channel independence: channel 0 full, then a write to 16'h8000.
  - Required: accepted with cpu_stall=0; ch_wvalid[2]=1.
- Push and pop on the same cycle with count=2:
  - Required: count stays 2 and the order is preserved.
  - Drive 10 push/pop cycles to exercise pointer wrap.
  - Required: no loss and no duplicates.
- Read and unmapped access:
  - Read: ch_rdata slice2=16'h1234, raddr=16'h8003.
  - Required: cpu_rdata=16'h1234 one cycle later.
  - Unmapped write to 16'hC000, 300 times.
  - Required: no FIFO change, and err_count=255, saturated.
  - Asynchronous reset asserted mid-sequence clears all state immediately.

Source files
------------

// File: rtl/io_hub.sv
// io_hub: memory-mapped I/O hub with per-channel write FIFOs and registered reads
module io_hub #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int SEL_W = 2,
  parameter int NUM_CH = 3,
  parameter int DEPTH = 4,
  localparam int LOCAL_W = ADDR_W - SEL_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         cpu_waddr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic                      cpu_wenable,
  output logic                      cpu_stall,
  input  logic [ADDR_W-1:0]         cpu_raddr,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic [NUM_CH-1:0]         ch_wvalid,
  output logic [NUM_CH*LOCAL_W-1:0] ch_waddr,
  output logic [NUM_CH*DATA_W-1:0]  ch_wdata,
  input  logic [NUM_CH-1:0]         ch_wready,
  output logic [NUM_CH*LOCAL_W-1:0] ch_raddr,
  input  logic [NUM_CH*DATA_W-1:0]  ch_rdata,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [7:0]                err_count
);
  localparam int PW = $clog2(DEPTH);
  logic [SEL_W-1:0] wsel, rsel;
  logic wmapped, rmapped, r_unmap_q, err_inc;
  logic [NUM_CH-1:0] full_hit;
  logic [DATA_W-1:0] rd_mux;
  assign wsel = cpu_waddr[ADDR_W-1 -: SEL_W];
  assign rsel = cpu_raddr[ADDR_W-1 -: SEL_W];
  assign wmapped = 32'(wsel) < NUM_CH;
  assign rmapped = 32'(rsel) < NUM_CH;
  assign cpu_stall = |full_hit;
  assign ch_busy = ch_wvalid;
  assign ch_raddr = {NUM_CH{cpu_raddr[LOCAL_W-1:0]}};
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic [LOCAL_W+DATA_W-1:0] mem [DEPTH];
    logic hit, push, pop;
    assign hit = cpu_wenable && wsel == SEL_W'(i);
    // full is judged on the registered count, so a same-cycle pop never frees a slot
    assign full_hit[i] = hit && cnt == (PW+1)'(DEPTH);
    assign push = hit && !full_hit[i];
    assign pop = ch_wvalid[i] && ch_wready[i];
    assign ch_wvalid[i] = cnt != '0;
    assign {ch_waddr[i*LOCAL_W +: LOCAL_W], ch_wdata[i*DATA_W +: DATA_W]} = ch_wvalid[i] ? mem[rp] : '0;
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      end
    always_ff @(posedge clock)
      if (push) mem[wp] <= {cpu_waddr[LOCAL_W-1:0], cpu_wdata};
  end
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (rsel == SEL_W'(k)) rd_mux = ch_rdata[k*DATA_W +: DATA_W];
  end
  // an unmapped read only counts on the cycle it enters the unmapped region
  assign err_inc = (cpu_wenable && !wmapped) || (!rmapped && !r_unmap_q);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cpu_rdata <= '0;
      r_unmap_q <= 1'b0;
      err_count <= '0;
    end else begin
      cpu_rdata <= rd_mux;
      r_unmap_q <= !rmapped;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_io_hub.sv
// tb_io_hub: directed self-checking bench for io_hub
module tb_io_hub;
  logic clock = 1'b0, reset = 1'b0;
  logic [15:0] cpu_waddr = '0, cpu_wdata = '0, cpu_raddr = '0;
  logic cpu_wenable = 1'b0;
  logic cpu_stall;
  logic [15:0] cpu_rdata;
  logic [2:0] ch_wvalid, ch_busy, ch_wready = '0;
  logic [41:0] ch_waddr, ch_raddr;
  logic [47:0] ch_wdata, ch_rdata = '0;
  logic [7:0] err_count;
  int n = 0, errs = 0;

  io_hub dut (
    .clock(clock), .reset(reset), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_wenable(cpu_wenable), .cpu_stall(cpu_stall), .cpu_raddr(cpu_raddr),
    .cpu_rdata(cpu_rdata), .ch_wvalid(ch_wvalid), .ch_waddr(ch_waddr),
    .ch_wdata(ch_wdata), .ch_wready(ch_wready), .ch_raddr(ch_raddr),
    .ch_rdata(ch_rdata), .ch_busy(ch_busy), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("rst_wvalid", ch_wvalid, 0);
    chk("rst_busy", ch_busy, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_err", err_count, 0);
    chk("rst_wdata", ch_wdata, 0);
    reset = 1'b1;
    cpu_raddr = 16'h3ABC;
    #1;
    chk("raddr_bcast", ch_raddr, {3{14'h3ABC}});
    cyc();
    chk("idle_rdata", cpu_rdata, 0);
    chk("idle_wvalid", ch_wvalid, 0);
    cpu_raddr = 16'h0000;
    // single write to channel 1
    cpu_waddr = 16'h4005; cpu_wdata = 16'hBEEF; cpu_wenable = 1'b1;
    cyc();
    cpu_wenable = 1'b0;
    chk("sw_wvalid", ch_wvalid, 3'b010);
    chk("sw_busy", ch_busy, 3'b010);
    chk("sw_waddr1", ch_waddr[27:14], 14'h0005);
    chk("sw_wdata1", ch_wdata[31:16], 16'hBEEF);
    ch_wready = 3'b010;
    cyc();
    ch_wready = 3'b000;
    chk("sw_popped", ch_wvalid, 3'b000);
    // fill channel 0
    for (int k = 1; k <= 4; k++) begin
      cpu_waddr = 16'(k); cpu_wdata = 16'(k); cpu_wenable = 1'b1;
      #1;
      chk("fill_stall", cpu_stall, 0);
      cyc();
    end
    cpu_waddr = 16'h0005; cpu_wdata = 16'h0005;
    #1;
    chk("full_stall", cpu_stall, 1);
    // another channel is unaffected by channel 0 being full
    cpu_waddr = 16'h8000; cpu_wdata = 16'hAAAA;
    #1;
    chk("xch_stall", cpu_stall, 0);
    cyc();
    chk("xch_wvalid", ch_wvalid, 3'b101);
    cpu_waddr = 16'h0005; cpu_wdata = 16'h0005;
    #1;
    chk("full_stall2", cpu_stall, 1);
    chk("drain_head1", ch_wdata[15:0], 16'd1);
    ch_wready = 3'b001;
    cyc();
    chk("stall_clear", cpu_stall, 0);
    for (int k = 2; k <= 5; k++) begin
      chk("drain_data", ch_wdata[15:0], 16'(k));
      chk("drain_addr", ch_waddr[13:0], 14'(k));
      cyc();
      cpu_wenable = 1'b0;
    end
    chk("drain_empty", ch_wvalid[0], 0);
    chk("ch2_head", ch_wdata[47:32], 16'hAAAA);
    ch_wready = 3'b100;
    cyc();
    ch_wready = 3'b000;
    chk("ch2_empty", ch_wvalid, 3'b000);
    // push and pop together on channel 1 with two entries queued
    cpu_waddr = 16'h4000; cpu_wenable = 1'b1;
    cpu_wdata = 16'h0100;
    cyc();
    cpu_wdata = 16'h0101;
    cyc();
    for (int j = 0; j < 10; j++) begin
      cpu_wdata = 16'h0102 + 16'(j);
      ch_wready = 3'b010;
      #1;
      chk("pp_head", ch_wdata[31:16], 16'h0100 + 16'(j));
      chk("pp_stall", cpu_stall, 0);
      cyc();
    end
    cpu_wenable = 1'b0;
    chk("pp_tail0", ch_wdata[31:16], 16'h010A);
    cyc();
    chk("pp_tail1", ch_wdata[31:16], 16'h010B);
    cyc();
    ch_wready = 3'b000;
    chk("pp_empty", ch_wvalid, 3'b000);
    // registered reads
    ch_rdata = {16'h1234, 16'h5678, 16'h9ABC};
    cpu_raddr = 16'h8003;
    #1;
    chk("rd_raddr", ch_raddr[41:28], 14'h0003);
    cyc();
    chk("rd_ch2", cpu_rdata, 16'h1234);
    cpu_raddr = 16'h4001;
    cyc();
    chk("rd_ch1", cpu_rdata, 16'h5678);
    chk("rd_noerr", err_count, 0);
    // unmapped reads and writes
    cpu_raddr = 16'hC000;
    cyc();
    chk("ur_rdata", cpu_rdata, 0);
    chk("ur_err", err_count, 1);
    cyc();
    chk("ur_once", err_count, 1);
    cpu_raddr = 16'h0000;
    cyc();
    cpu_raddr = 16'hC004; cpu_waddr = 16'hC000; cpu_wenable = 1'b1;
    #1;
    chk("uw_stall", cpu_stall, 0);
    cyc();
    chk("urw_single", err_count, 2);
    repeat (299) cyc();
    cpu_wenable = 1'b0;
    chk("uw_sat", err_count, 255);
    chk("uw_nofifo", ch_wvalid, 3'b000);
    // asynchronous reset mid-transfer
    cpu_raddr = 16'h8003; cpu_waddr = 16'h0011; cpu_wdata = 16'h0077; cpu_wenable = 1'b1;
    cyc();
    cyc();
    cpu_wenable = 1'b0;
    chk("pre_rst_wvalid", ch_wvalid, 3'b001);
    chk("pre_rst_rdata", cpu_rdata, 16'h1234);
    #2 reset = 1'b0;
    #1;
    chk("arst_wvalid", ch_wvalid, 3'b000);
    chk("arst_err", err_count, 0);
    chk("arst_rdata", cpu_rdata, 0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("post_rst_wvalid", ch_wvalid, 3'b000);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
